// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared FSM state type and timeout read-data fill rule for reg_bus_arbiter
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} arb_state_e;
  localparam logic TIMEOUT_FILL = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_rr_ptr with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] w_j;
  // Scan farthest-first so the nearest requester from the pointer overwrites the rest
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (i_req_valid[w_j]) begin
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of the register-file port, one outstanding transaction.
// REG_ARB_TIMEOUT_EN adds a WAIT_RSP timeout that answers with all-ones data and rsp_err.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       rf_cmd_valid,
  input  logic                       rf_cmd_ready,
  output logic                       rf_cmd_we,
  output logic [ADDR_W-1:0]          rf_cmd_addr,
  output logic [DATA_W-1:0]          rf_cmd_wdata,
  input  logic                       rf_rsp_valid,
  input  logic [DATA_W-1:0]          rf_rsp_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e r_state, w_next;
  logic [IW-1:0] r_ptr, r_grant, w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic w_any, w_timeout, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [ADDR_W-1:0] w_addr [NUM_REQ];
  logic [DATA_W-1:0] w_wdata [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_ptr),
    .o_grant     (w_gnt),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  // Held at zero outside WAIT_RSP, so it is always clear on entry
  always_ff @(posedge clk) begin
    if (rst || r_state != WAIT_RSP) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end
  assign w_timeout = (r_state == WAIT_RSP) && !rf_rsp_valid && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (r_state == WAIT_RSP && rf_rsp_valid) r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end
  assign rsp_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_any ? ISSUE : IDLE;
      ISSUE:    w_next = rf_cmd_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP: w_next = (rf_rsp_valid || w_timeout) ? RESPOND : WAIT_RSP;
      RESPOND:  w_next = rsp_ready[r_grant] ? IDLE : RESPOND;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_idx;
        r_we    <= req_we[w_idx];
        r_addr  <= w_addr[w_idx];
        r_wdata <= w_wdata[w_idx];
      end
      if (r_state == WAIT_RSP && rf_rsp_valid) r_rdata <= rf_rsp_rdata;
      else if (w_timeout) r_rdata <= {DATA_W{TIMEOUT_FILL}};
      if (r_state == RESPOND && rsp_ready[r_grant])
        r_ptr <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
    end
  end

  assign req_ready    = (r_state == IDLE) ? w_gnt : '0;
  assign rsp_valid    = (r_state == RESPOND) ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_rdata    = r_rdata;
  assign rf_cmd_valid = (r_state == ISSUE);
  assign rf_cmd_we    = r_we;
  assign rf_cmd_addr  = r_addr;
  assign rf_cmd_wdata = r_wdata;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed + randomized bench against a transaction-level round-robin / register-file model
module tb_reg_bus_arbiter;
  localparam int N = 2, AW = 8, DW = 16, TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, rf_cmd_wdata, rf_rsp_rdata = '0;
  logic rsp_err, rf_cmd_valid, rf_cmd_ready = 1'b0, rf_cmd_we, rf_rsp_valid = 1'b0;
  logic [AW-1:0] rf_cmd_addr;

  reg_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rf_cmd_valid(rf_cmd_valid),
    .rf_cmd_ready(rf_cmd_ready), .rf_cmd_we(rf_cmd_we), .rf_cmd_addr(rf_cmd_addr),
    .rf_cmd_wdata(rf_cmd_wdata), .rf_rsp_valid(rf_rsp_valid), .rf_rsp_rdata(rf_rsp_rdata)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0, m_ptr = 0;
  logic p_valid [N];
  logic p_we [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];
  logic [DW-1:0] mem [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_cmd_valid, rf_cmd_we, rf_cmd_addr, rf_cmd_wdata});
  endfunction

  // Round-robin rule: first pending requester at or after the pointer, wrapping
  function automatic int pick();
    for (int k = 0; k < N; k++) if (p_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = p_valid[i];
      req_we[i] = p_we[i];
      req_addr[i*AW +: AW] = p_addr[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1;
    p_we[i] = we;
    p_addr[i] = a;
    p_wdata[i] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("reset_outs", outs(), 64'd0);
    tick();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic txn(input int cs, input int rd, input int rs);
    int w, n;
    logic [DW-1:0] d;
    w = pick();
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check("grant_latency", 64'(n), 64'd0);
    check("grant", 64'(req_ready), 64'(1) << w);
    tick();
    p_valid[w] = 1'b0;
    drive();
    for (int k = 0; k <= cs; k++) begin
      check("cmd_valid", 64'(rf_cmd_valid), 64'd1);
      check("cmd_fields", 64'({rf_cmd_we, rf_cmd_addr, rf_cmd_wdata}), 64'({p_we[w], p_addr[w], p_wdata[w]}));
      check("ready_busy", 64'(req_ready), 64'd0);
      rf_cmd_ready = (k == cs);
      rf_rsp_valid = 1'($urandom);
      rf_rsp_rdata = 16'($urandom);
      tick();
    end
    rf_cmd_ready = 1'b0;
    d = p_we[w] ? 16'($urandom) : mem[p_addr[w]];
    if (p_we[w]) mem[p_addr[w]] = p_wdata[w];
    for (int k = 0; k <= rd; k++) begin
      check("wait_quiet", 64'({rf_cmd_valid, rsp_valid}), 64'd0);
      rf_rsp_valid = (k == rd);
      rf_rsp_rdata = (k == rd) ? d : 16'($urandom);
      tick();
    end
    for (int k = 0; k <= rs; k++) begin
      check("rsp_valid", 64'(rsp_valid), 64'(1) << w);
      if (!p_we[w]) check("rsp_rdata", 64'(rsp_rdata), 64'(d));
      check("rsp_err", 64'(rsp_err), 64'd0);
      check("ready_rsp", 64'(req_ready), 64'd0);
      rsp_ready = (k == rs) ? (N'(1) << w) : (N'($urandom) & ~(N'(1) << w));
      rf_rsp_valid = 1'($urandom);
      rf_rsp_rdata = 16'($urandom);
      tick();
    end
    rsp_ready = '0;
    rf_rsp_valid = 1'b0;
    m_ptr = (w + 1) % N;
  endtask

  task automatic stall_test();
    int n;
    logic [DW-1:0] d;
    set_req(1, 1'b0, 8'h33, 16'h0);
    drive();
    check("to_grant", 64'(req_ready), 64'(1) << pick());
    tick();
    p_valid[1] = 1'b0;
    drive();
    rf_cmd_ready = 1'b1;
    tick();
    rf_cmd_ready = 1'b0;
    n = 0;
`ifdef REG_ARB_TIMEOUT_EN
    while (rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", 64'(n), 64'(TO));
    check("to_err", 64'(rsp_err), 64'd1);
    check("to_rdata", 64'(rsp_rdata), 64'hFFFF);
`else
    while (rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    check("no_timeout", 64'(n), 64'd40);
    d = mem[8'h33];
    rf_rsp_valid = 1'b1;
    rf_rsp_rdata = d;
    tick();
    rf_rsp_valid = 1'b0;
    check("late_valid", 64'(rsp_valid), 64'd2);
    check("late_rdata", 64'(rsp_rdata), 64'(d));
    check("late_err", 64'(rsp_err), 64'd0);
`endif
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    m_ptr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0;
      p_we[i] = 1'b0;
      p_addr[i] = '0;
      p_wdata[i] = '0;
    end
    @(negedge clk);
    do_reset();
    set_req(0, 1'b1, 8'h10, 16'hBEEF);
    drive();
    txn(0, 0, 0);
    set_req(0, 1'b0, 8'h10, 16'h0);
    drive();
    txn(0, 0, 0);
    check("readback", 64'(mem[8'h10]), 64'hBEEF);
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b0, 8'h01, 16'h0);
      set_req(1, 1'b0, 8'h02, 16'h0);
      drive();
      check("first_port0", 64'(pick()), 64'd0);
      txn(0, 0, 0);
      txn(0, 0, 0);
    end
    set_req(1, 1'b1, 8'h44, 16'h5A5A);
    drive();
    txn(5, 0, 3);
    mem[8'h2A] = 16'h1234;
    set_req(1, 1'b0, 8'h2A, 16'h0);
    drive();
    txn(0, 7, 0);
    set_req(0, 1'b1, 8'h05, 16'h0F0F);
    drive();
    txn(1, 1, 1);
    set_req(0, 1'b0, 8'h55, 16'h0);
    drive();
    check("abort_grant", 64'(req_ready), 64'(1) << pick());
    tick();
    p_valid[0] = 1'b0;
    drive();
    rf_cmd_ready = 1'b1;
    tick();
    rf_cmd_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("reset_abort", outs(), 64'd0);
    rst = 1'b0;
    m_ptr = 0;
    tick();
    check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    set_req(0, 1'b0, 8'h07, 16'h0);
    set_req(1, 1'b0, 8'h08, 16'h0);
    drive();
    txn(0, 0, 0);
    txn(0, 0, 0);
    stall_test();
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < N; i++)
        if (!p_valid[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'($urandom), 8'($urandom), 16'($urandom));
      if (pick() < 0) set_req($urandom_range(N - 1, 0), 1'($urandom), 8'($urandom), 16'($urandom));
      drive();
      txn($urandom_range(4, 0), $urandom_range(7, 0), $urandom_range(3, 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
